mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_req_arbiter_if.sv | 52 +++++
 rtl/mem_arb_tid_alloc.sv | 62 ++++++
 rtl/mem_req_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the memory request arbiter.
//   owner_e     : which requester owns an in-flight transaction ID
//   tid_entry_t : one row of the transaction-ID table {busy, owner, we}
//   other_owner : returns the requester that is not the given one
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_e;

  typedef struct packed {
    logic   busy;
    owner_e owner;
    logic   we;
  } tid_entry_t;

  function automatic owner_e other_owner(input owner_e o);
    return (o == ICACHE) ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_if
// Bundles the request, memory-port and response signals of mem_req_arbiter.
//   slave  : the arbiter's view (consumes *_i, drives *_o)
//   master : the environment's view (drives *_i, consumes *_o)
// Parameters ADDR_WIDTH / DATA_WIDTH / TID_WIDTH must match the arbiter's.
// -----------------------------------------------------------------------------
interface mem_req_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = 2
);
  logic                  icache_req_valid_i;
  logic                  icache_req_ready_o;
  logic [ADDR_WIDTH-1:0] icache_req_addr_i;
  logic                  dcache_req_valid_i;
  logic                  dcache_req_ready_o;
  logic [ADDR_WIDTH-1:0] dcache_req_addr_i;
  logic                  dcache_req_we_i;
  logic [DATA_WIDTH-1:0] dcache_req_wdata_i;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_req_addr_o;
  logic                  mem_req_we_o;
  logic [DATA_WIDTH-1:0] mem_req_wdata_o;
  logic [TID_WIDTH-1:0]  mem_req_tid_o;
  logic                  mem_rsp_valid_i;
  logic [TID_WIDTH-1:0]  mem_rsp_tid_i;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata_i;
  logic                  icache_rsp_valid_o;
  logic                  dcache_rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  err_unexp_rsp_o;

  modport slave (
    input  icache_req_valid_i, icache_req_addr_i,
    input  dcache_req_valid_i, dcache_req_addr_i, dcache_req_we_i, dcache_req_wdata_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    output icache_req_ready_o, dcache_req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_tid_o,
    output icache_rsp_valid_o, dcache_rsp_valid_o, rsp_rdata_o, err_unexp_rsp_o
  );

  modport master (
    output icache_req_valid_i, icache_req_addr_i,
    output dcache_req_valid_i, dcache_req_addr_i, dcache_req_we_i, dcache_req_wdata_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    input  icache_req_ready_o, dcache_req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_tid_o,
    input  icache_rsp_valid_o, dcache_rsp_valid_o, rsp_rdata_o, err_unexp_rsp_o
  );
endinterface

// File: rtl/mem_arb_tid_alloc.sv
// -----------------------------------------------------------------------------
// mem_arb_tid_alloc
// Transaction-ID table with lowest-free priority encoder.
//   clk_i, rst_i     : clock, synchronous active-high reset (frees every ID)
//   alloc_i          : mark alloc_tid_i busy, recording owner and we
//   free_i, rsp_tid_i: clear the busy bit of rsp_tid_i
//   rsp_entry_o      : table row for rsp_tid_i (combinational lookup)
//   free_tid_o       : lowest-index non-busy ID (valid when !full_o)
//   full_o           : every ID is busy
// Allocation and free both land on the next edge, so an ID released this
// cycle is still seen as busy by the encoder until then.
// -----------------------------------------------------------------------------
module mem_arb_tid_alloc
  import mem_arb_pkg::*;
#(
  parameter int TID_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_i,
  input  owner_e               alloc_owner_i,
  input  logic                 alloc_we_i,
  input  logic [TID_WIDTH-1:0] alloc_tid_i,
  input  logic                 free_i,
  input  logic [TID_WIDTH-1:0] rsp_tid_i,
  output tid_entry_t           rsp_entry_o,
  output logic [TID_WIDTH-1:0] free_tid_o,
  output logic                 full_o
);
  localparam int NUM_IDS = 2 ** TID_WIDTH;

  tid_entry_t [NUM_IDS-1:0] w_table;
  logic       [NUM_IDS-1:0] w_busy;

  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_entry
    tid_entry_t r_entry;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_entry <= '{busy: 1'b0, owner: ICACHE, we: 1'b0};
      end else if (alloc_i && (alloc_tid_i == TID_WIDTH'(gi))) begin
        r_entry <= '{busy: 1'b1, owner: alloc_owner_i, we: alloc_we_i};
      end else if (free_i && (rsp_tid_i == TID_WIDTH'(gi))) begin
        r_entry.busy <= 1'b0;
      end
    end

    assign w_table[gi] = r_entry;
    assign w_busy[gi]  = r_entry.busy;
  end

  assign rsp_entry_o = w_table[rsp_tid_i];
  assign full_o      = &w_busy;

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    free_tid_o = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!w_busy[i]) free_tid_o = TID_WIDTH'(i);
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Arbitrates icache and dcache requests onto one memory port, tags each
// transfer with the lowest free transaction ID, and routes responses back
// to the owner of that ID.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : mem_req_arbiter_if.slave (request, memory-port, response signals)
// Parameters: ADDR_WIDTH, DATA_WIDTH, TID_WIDTH, MAX_STORES (outstanding writes).
// Build option: define MEM_ARB_ICACHE_PRIO_EN for fixed icache priority;
// otherwise the two requesters are served round-robin.
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = 2,
  parameter int MAX_STORES = 7
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_req_arbiter_if.slave bus
);
  localparam int                 CNT_WIDTH = $clog2(MAX_STORES + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_STORES);

  logic [CNT_WIDTH-1:0] r_store_cnt;
  owner_e               r_prio;
  logic                 r_locked;
  owner_e               r_lock_owner;
  logic [TID_WIDTH-1:0] r_lock_tid;
  logic                 r_err;

  tid_entry_t           w_rsp_entry;
  logic [TID_WIDTH-1:0] w_free_tid;
  logic                 w_full;
  logic                 w_rsp_hit, w_rsp_unexp, w_store_inc, w_store_dec, w_store_room;
  logic                 w_i_elig, w_d_elig, w_valid, w_xfer, w_we;
  owner_e               w_grant;
  logic [TID_WIDTH-1:0] w_tid;

  mem_arb_tid_alloc #(.TID_WIDTH(TID_WIDTH)) u_tid_alloc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (w_xfer),
    .alloc_owner_i (w_grant),
    .alloc_we_i    (w_we),
    .alloc_tid_i   (w_tid),
    .free_i        (w_rsp_hit),
    .rsp_tid_i     (bus.mem_rsp_tid_i),
    .rsp_entry_o   (w_rsp_entry),
    .free_tid_o    (w_free_tid),
    .full_o        (w_full)
  );

  assign w_rsp_hit   = bus.mem_rsp_valid_i && w_rsp_entry.busy;
  assign w_rsp_unexp = bus.mem_rsp_valid_i && !w_rsp_entry.busy;
  assign w_store_dec = w_rsp_hit && w_rsp_entry.we;
  // A write response arriving this cycle releases a store slot, so a new
  // write may go out alongside it without the count ever exceeding the cap.
  assign w_store_room = (r_store_cnt < MAX_CNT) || w_store_dec;

  assign w_i_elig = bus.icache_req_valid_i && !w_full;
  assign w_d_elig = bus.dcache_req_valid_i && !w_full &&
                    (!bus.dcache_req_we_i || w_store_room);

  always_comb begin
    w_grant = ICACHE;
    w_tid   = w_free_tid;
    w_valid = 1'b0;
    if (r_locked) begin
      // Stalled last cycle: replay the same grant and the same ID so the
      // memory side sees a stable request even if a lower ID freed meanwhile.
      w_grant = r_lock_owner;
      w_tid   = r_lock_tid;
      w_valid = (r_lock_owner == ICACHE) ? bus.icache_req_valid_i : bus.dcache_req_valid_i;
    end else begin
      w_valid = w_i_elig || w_d_elig;
`ifdef MEM_ARB_ICACHE_PRIO_EN
      w_grant = w_i_elig ? ICACHE : DCACHE;
`else
      if (w_i_elig && w_d_elig) w_grant = r_prio;
      else                      w_grant = w_i_elig ? ICACHE : DCACHE;
`endif
    end
    if (rst_i) w_valid = 1'b0;
  end

  assign w_xfer      = w_valid && bus.mem_req_ready_i;
  assign w_we        = (w_grant == DCACHE) && bus.dcache_req_we_i;
  assign w_store_inc = w_xfer && w_we;

  assign bus.mem_req_valid_o    = w_valid;
  assign bus.mem_req_addr_o     = (w_grant == DCACHE) ? bus.dcache_req_addr_i : bus.icache_req_addr_i;
  assign bus.mem_req_we_o       = w_we;
  assign bus.mem_req_wdata_o    = (w_grant == DCACHE) ? bus.dcache_req_wdata_i : '0;
  assign bus.mem_req_tid_o      = w_tid;
  assign bus.icache_req_ready_o = w_valid && (w_grant == ICACHE) && bus.mem_req_ready_i;
  assign bus.dcache_req_ready_o = w_valid && (w_grant == DCACHE) && bus.mem_req_ready_i;
  assign bus.icache_rsp_valid_o = !rst_i && w_rsp_hit && (w_rsp_entry.owner == ICACHE);
  assign bus.dcache_rsp_valid_o = !rst_i && w_rsp_hit && (w_rsp_entry.owner == DCACHE);
  assign bus.rsp_rdata_o        = bus.mem_rsp_rdata_i;
  assign bus.err_unexp_rsp_o    = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_store_cnt  <= '0;
      r_prio       <= ICACHE;
      r_locked     <= 1'b0;
      r_lock_owner <= ICACHE;
      r_lock_tid   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_prio   <= other_owner(w_grant);
        r_locked <= 1'b0;
      end else if (w_valid) begin
        r_locked     <= 1'b1;
        r_lock_owner <= w_grant;
        r_lock_tid   <= w_tid;
      end else begin
        r_locked <= 1'b0;
      end

      if (w_rsp_unexp) r_err <= 1'b1;

      // Saturating at both ends; simultaneous inc and dec cancel.
      case ({w_store_inc, w_store_dec})
        2'b10:   if (r_store_cnt != MAX_CNT) r_store_cnt <= r_store_cnt + 1'b1;
        2'b01:   if (r_store_cnt != '0)      r_store_cnt <= r_store_cnt - 1'b1;
        default: r_store_cnt <= r_store_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter. Instance u_a uses the default 4 IDs;
// instance u_b uses 8 IDs so seven writes can be outstanding at once.
// Expected grants are queued when a stimulus phase starts and popped on
// every observed transfer.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(2)) ifa ();
  mem_req_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(3)) ifb ();

  mem_req_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(2), .MAX_STORES(7)) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  mem_req_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(3), .MAX_STORES(7)) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  typedef struct {
    logic        own;   // 0 = icache, 1 = dcache
    logic [2:0]  tid;
    logic [63:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [1:0] rsp_tids [4];
    logic       rsp_owns [4];

    rst = 1'b1;
    ifa.icache_req_valid_i = 1'b0; ifa.icache_req_addr_i = '0;
    ifa.dcache_req_valid_i = 1'b0; ifa.dcache_req_addr_i = '0;
    ifa.dcache_req_we_i = 1'b0;    ifa.dcache_req_wdata_i = '0;
    ifa.mem_req_ready_i = 1'b0;    ifa.mem_rsp_valid_i = 1'b0;
    ifa.mem_rsp_tid_i = '0;        ifa.mem_rsp_rdata_i = '0;
    ifb.icache_req_valid_i = 1'b0; ifb.icache_req_addr_i = '0;
    ifb.dcache_req_valid_i = 1'b0; ifb.dcache_req_addr_i = '0;
    ifb.dcache_req_we_i = 1'b0;    ifb.dcache_req_wdata_i = '0;
    ifb.mem_req_ready_i = 1'b0;    ifb.mem_rsp_valid_i = 1'b0;
    ifb.mem_rsp_tid_i = '0;        ifb.mem_rsp_rdata_i = '0;

    // ---- outputs quiet while reset is held, even with requests pending
    ifa.icache_req_valid_i = 1'b1; ifa.mem_req_ready_i = 1'b1;
    ifb.dcache_req_valid_i = 1'b1; ifb.mem_req_ready_i = 1'b1;
    tick(); tick(); #1;
    chk("rst_a_mem_valid", 64'(ifa.mem_req_valid_o), 0);
    chk("rst_a_icache_ready", 64'(ifa.icache_req_ready_o), 0);
    chk("rst_b_mem_valid", 64'(ifb.mem_req_valid_o), 0);
    chk("rst_b_dcache_ready", 64'(ifb.dcache_req_ready_o), 0);
    ifa.icache_req_valid_i = 1'b0;
    ifb.dcache_req_valid_i = 1'b0;
    rst = 1'b0;
    tick(); #1;
    chk("post_rst_a_err", 64'(ifa.err_unexp_rsp_o), 0);
    chk("post_rst_b_err", 64'(ifb.err_unexp_rsp_o), 0);
    chk("post_rst_a_idle", 64'(ifa.mem_req_valid_o), 0);

    // ---- round robin, both valid, ready always high
    ifa.icache_req_valid_i = 1'b1; ifa.icache_req_addr_i = 64'h100;
    ifa.dcache_req_valid_i = 1'b1; ifa.dcache_req_addr_i = 64'h200;
    ifa.dcache_req_we_i = 1'b0;
    sbq.push_back('{own: 1'b0, tid: 3'd0, addr: 64'h100});
    sbq.push_back('{own: 1'b1, tid: 3'd1, addr: 64'h200});
    sbq.push_back('{own: 1'b0, tid: 3'd2, addr: 64'h100});
    sbq.push_back('{own: 1'b1, tid: 3'd3, addr: 64'h200});
    for (int c = 0; c < 8 && sbq.size() > 0; c++) begin
      #1;
      if (ifa.mem_req_valid_o && ifa.mem_req_ready_i) begin
        e = sbq.pop_front();
        $display("a xfer owner=%0d tid=%0d addr=%0h", ifa.dcache_req_ready_o, ifa.mem_req_tid_o, ifa.mem_req_addr_o);
        chk("rr_owner", 64'(ifa.dcache_req_ready_o), 64'(e.own));
        chk("rr_other_ready", 64'(ifa.icache_req_ready_o), 64'(!e.own));
        chk("rr_tid", 64'(ifa.mem_req_tid_o), 64'(e.tid));
        chk("rr_addr", ifa.mem_req_addr_o, e.addr);
      end
      tick();
    end
    chk("rr_sb_drained", 64'(sbq.size()), 0);
    #1;
    chk("full_mem_valid", 64'(ifa.mem_req_valid_o), 0);
    chk("full_icache_ready", 64'(ifa.icache_req_ready_o), 0);
    chk("full_dcache_ready", 64'(ifa.dcache_req_ready_o), 0);

    // response to tid 1 (dcache read); ID not reusable until next edge
    ifa.mem_rsp_valid_i = 1'b1; ifa.mem_rsp_tid_i = 2'd1; ifa.mem_rsp_rdata_i = 64'hBEEF;
    #1;
    chk("rsp1_dcache_valid", 64'(ifa.dcache_rsp_valid_o), 1);
    chk("rsp1_icache_valid", 64'(ifa.icache_rsp_valid_o), 0);
    chk("rsp1_rdata", ifa.rsp_rdata_o, 64'hBEEF);
    chk("rsp1_no_same_cycle_reuse", 64'(ifa.mem_req_valid_o), 0);
    tick();
    ifa.mem_rsp_valid_i = 1'b0;
    #1;
    chk("reuse_icache_ready", 64'(ifa.icache_req_ready_o), 1);
    chk("reuse_tid", 64'(ifa.mem_req_tid_o), 1);
    tick();
    ifa.icache_req_valid_i = 1'b0;
    ifa.dcache_req_valid_i = 1'b0;

    // drain: tid0 I, tid2 I, tid3 D, tid1 I
    rsp_tids = '{2'd0, 2'd2, 2'd3, 2'd1};
    rsp_owns = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      ifa.mem_rsp_valid_i = 1'b1; ifa.mem_rsp_tid_i = rsp_tids[k];
      #1;
      $display("a rsp tid=%0d icache=%0d dcache=%0d", rsp_tids[k], ifa.icache_rsp_valid_o, ifa.dcache_rsp_valid_o);
      chk("drain_dcache_rsp", 64'(ifa.dcache_rsp_valid_o), 64'(rsp_owns[k]));
      chk("drain_icache_rsp", 64'(ifa.icache_rsp_valid_o), 64'(!rsp_owns[k]));
      tick();
    end
    ifa.mem_rsp_valid_i = 1'b0;

    // ---- stall: dcache write granted, ready low for 3 cycles
    ifa.dcache_req_valid_i = 1'b1; ifa.dcache_req_addr_i = 64'h300;
    ifa.dcache_req_we_i = 1'b1;    ifa.dcache_req_wdata_i = 64'h55;
    ifa.mem_req_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ifa.icache_req_valid_i = 1'b1; ifa.icache_req_addr_i = 64'h400;
      end
      #1;
      $display("a stall cycle=%0d addr=%0h tid=%0d", c, ifa.mem_req_addr_o, ifa.mem_req_tid_o);
      chk("stall_valid", 64'(ifa.mem_req_valid_o), 1);
      chk("stall_addr", ifa.mem_req_addr_o, 64'h300);
      chk("stall_tid", 64'(ifa.mem_req_tid_o), 0);
      chk("stall_we", 64'(ifa.mem_req_we_o), 1);
      chk("stall_icache_ready", 64'(ifa.icache_req_ready_o), 0);
      chk("stall_dcache_ready", 64'(ifa.dcache_req_ready_o), 0);
      tick();
    end
    ifa.mem_req_ready_i = 1'b1;
    #1;
    chk("stall_release_dcache", 64'(ifa.dcache_req_ready_o), 1);
    chk("stall_release_wdata", ifa.mem_req_wdata_o, 64'h55);
    tick();
    ifa.dcache_req_valid_i = 1'b0; ifa.dcache_req_we_i = 1'b0;
    #1;
    chk("after_stall_icache", 64'(ifa.icache_req_ready_o), 1);
    chk("after_stall_tid", 64'(ifa.mem_req_tid_o), 1);
    chk("after_stall_addr", ifa.mem_req_addr_o, 64'h400);
    tick();
    ifa.icache_req_valid_i = 1'b0;
    ifa.mem_rsp_valid_i = 1'b1; ifa.mem_rsp_tid_i = 2'd0;
    #1;
    chk("wr_rsp_dcache", 64'(ifa.dcache_rsp_valid_o), 1);
    tick();
    ifa.mem_rsp_tid_i = 2'd1;
    #1;
    chk("rd_rsp_icache", 64'(ifa.icache_rsp_valid_o), 1);
    tick();

    // ---- unexpected response for idle tid 2
    ifa.mem_rsp_tid_i = 2'd2; ifa.mem_rsp_rdata_i = 64'hDEAD;
    #1;
    chk("unexp_icache_rsp", 64'(ifa.icache_rsp_valid_o), 0);
    chk("unexp_dcache_rsp", 64'(ifa.dcache_rsp_valid_o), 0);
    tick();
    ifa.mem_rsp_valid_i = 1'b0;
    #1;
    chk("unexp_err_set", 64'(ifa.err_unexp_rsp_o), 1);

    // three icache reads get tids 0,1,2 (table untouched by the bad response)
    ifa.icache_req_valid_i = 1'b1; ifa.icache_req_addr_i = 64'h500;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("busy3_tid", 64'(ifa.mem_req_tid_o), 64'(k));
      tick();
    end
    ifa.icache_req_valid_i = 1'b0;
    #1;
    chk("err_sticky", 64'(ifa.err_unexp_rsp_o), 1);

    // ---- reset with 3 IDs busy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_err_clear", 64'(ifa.err_unexp_rsp_o), 0);
    ifa.icache_req_valid_i = 1'b1;
    #1;
    chk("rst_first_tid", 64'(ifa.mem_req_tid_o), 0);
    chk("rst_first_ready", 64'(ifa.icache_req_ready_o), 1);
    tick();
    ifa.icache_req_valid_i = 1'b0;
    ifa.mem_rsp_valid_i = 1'b1; ifa.mem_rsp_tid_i = 2'd1;
    #1;
    chk("stale_rsp_dropped", 64'(ifa.icache_rsp_valid_o), 0);
    tick();
    ifa.mem_rsp_valid_i = 1'b0;
    #1;
    chk("stale_rsp_err", 64'(ifa.err_unexp_rsp_o), 1);

    // ---- instance b: seven outstanding writes saturate the store count
    ifb.dcache_req_valid_i = 1'b1; ifb.dcache_req_addr_i = 64'h1000;
    ifb.dcache_req_we_i = 1'b1;    ifb.dcache_req_wdata_i = 64'h77;
    for (int k = 0; k < 7; k++) sbq.push_back('{own: 1'b1, tid: 3'(k), addr: 64'h1000});
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      #1;
      if (ifb.mem_req_valid_o && ifb.mem_req_ready_i) begin
        e = sbq.pop_front();
        $display("b xfer owner=%0d tid=%0d addr=%0h", ifb.dcache_req_ready_o, ifb.mem_req_tid_o, ifb.mem_req_addr_o);
        chk("wr_owner", 64'(ifb.dcache_req_ready_o), 64'(e.own));
        chk("wr_tid", 64'(ifb.mem_req_tid_o), 64'(e.tid));
        chk("wr_we", 64'(ifb.mem_req_we_o), 1);
      end
      tick();
    end
    chk("wr_sb_drained", 64'(sbq.size()), 0);
    #1;
    chk("wr8_blocked_valid", 64'(ifb.mem_req_valid_o), 0);
    chk("wr8_blocked_ready", 64'(ifb.dcache_req_ready_o), 0);

    // write response and new write in the same cycle at the cap
    ifb.mem_rsp_valid_i = 1'b1; ifb.mem_rsp_tid_i = 3'd3;
    #1;
    chk("swap_rsp_dcache", 64'(ifb.dcache_rsp_valid_o), 1);
    chk("swap_wr_ready", 64'(ifb.dcache_req_ready_o), 1);
    chk("swap_wr_tid", 64'(ifb.mem_req_tid_o), 7);
    tick();
    ifb.mem_rsp_valid_i = 1'b0;
    #1;
    chk("swap_cnt_still_cap", 64'(ifb.mem_req_valid_o), 0);
    ifb.dcache_req_we_i = 1'b0;
    #1;
    chk("cap_read_ready", 64'(ifb.dcache_req_ready_o), 1);
    chk("cap_read_tid", 64'(ifb.mem_req_tid_o), 3);
    tick();
    ifb.dcache_req_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
